// File: rtl/seq_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcodes, datapath select codes.
// Pure type/constant package; no timing or flow-control content.
package seq_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_LW   = 6'b100000;
  localparam logic [OP_W-1:0] OP_SW   = 6'b100001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b100010;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b100011;
  localparam logic [OP_W-1:0] OP_J    = 6'b110000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_SE  = 2'd2;
  localparam logic [1:0] SRCB_ZE  = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RFUNC = 2'b10;
  localparam logic [1:0] ALUOP_IFUNC = 2'b11;

  localparam logic [1:0] RS2_R2 = 2'd0;
  localparam logic [1:0] RS2_R3 = 2'd1;
  localparam logic [1:0] RS2_R1 = 2'd2;

  // One-hot instruction class; all-zero means the opcode is illegal.
  typedef struct packed {
    logic r;
    logic i;
    logic lw;
    logic sw;
    logic br;
    logic j;
    logic halt;
  } op_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode into a one-hot class plus zero-extend and illegal flags.
// Latency: 0 cycles; backpressure: none.
module opcode_classifier
  import seq_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output op_class_t       cls_o,
  output logic            zext_o,
  output logic            illegal_o
);

  always_comb begin
    cls_o     = '0;
    zext_o    = 1'b0;
    illegal_o = 1'b0;
    if (opcode_i[5:4] == 2'b00) begin
      cls_o.r = 1'b1;
    end else if (opcode_i[5:4] == 2'b01) begin
      cls_o.i = 1'b1;
      zext_o  = opcode_i[3];
    end else begin
      case (opcode_i)
        OP_LW:          cls_o.lw   = 1'b1;
        OP_SW:          cls_o.sw   = 1'b1;
        OP_BEQ, OP_BNE: cls_o.br   = 1'b1;
        OP_J:           cls_o.j    = 1'b1;
        OP_HALT:        cls_o.halt = 1'b1;
        default:        illegal_o  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Main control FSM stepping the multicycle datapath through fetch/decode/execute/mem/writeback.
// Latency: R/I/SW 4, LW 5, branch/jump 3 cycles; backpressure: run low parks the FSM in FETCH.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           run,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           Instr26,
  output logic           RegSelect1,
  output logic [1:0]     RegSelect2,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUOp,
  output logic           halted,
  output logic           illegal_op,
  output logic           instr_retired,
  output logic [STW-1:0] dbg_state
);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [5:0]  op;
  op_class_t   cls;
  logic        zext;
  logic        op_bad;

  assign op = opcode[OPW-1 -: 6];

  opcode_classifier u_classifier (
    .opcode_i  (op),
    .cls_o     (cls),
    .zext_o    (zext),
    .illegal_o (op_bad)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    Instr26       = 1'b0;
    RegSelect1    = 1'b0;
    RegSelect2    = RS2_R2;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_B;
    PCSource      = PCS_ALU;
    ALUOp         = ALUOP_ADD;
    halted        = 1'b0;
    instr_retired = 1'b0;

    // Read-port selects follow the latched opcode for the whole instruction so A/B stay stable.
    if (state_q != S_FETCH) begin
      if (cls.r) begin
        RegSelect1 = 1'b1;
        RegSelect2 = RS2_R3;
      end else if (cls.i || cls.lw) begin
        RegSelect1 = 1'b1;
      end else if (cls.sw) begin
        RegSelect1 = 1'b1;
        RegSelect2 = RS2_R1;
      end
    end

    case (state_q)
      S_FETCH: begin
        if (run) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = SRCB_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_SE;
        if (cls.r)                    state_d = S_EXEC_R;
        else if (cls.i)               state_d = S_EXEC_I;
        else if (cls.lw || cls.sw)    state_d = S_MEM_ADDR;
        else if (cls.br)              state_d = S_BRANCH;
        else if (cls.j)               state_d = S_JUMP;
        else if (cls.halt)            state_d = S_HALT;
        else begin
          illegal_d     = 1'b1;
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_B;
        ALUOp   = ALUOP_RFUNC;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = zext ? SRCB_ZE : SRCB_SE;
        ALUOp   = ALUOP_IFUNC;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_SE;
        state_d = cls.lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite      = 1'b1;
        MemtoReg      = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite      = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = SRCA_A;
        ALUSrcB       = SRCB_B;
        ALUOp         = ALUOP_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = PCS_ALUOUT;
        Instr26       = op[0];
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCWrite       = 1'b1;
        PCSource      = PCS_JUMP;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Flag is visible in DECODE itself, before the sticky bit is clocked in.
    illegal_op = illegal_q | ((state_q == S_DECODE) && op_bad);

    // While reset is held the FETCH state must not leak IRWrite/PCWrite.
    if (reset) begin
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      MemtoReg      = 1'b0;
      Instr26       = 1'b0;
      RegSelect1    = 1'b0;
      RegSelect2    = RS2_R2;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_B;
      PCSource      = PCS_ALU;
      ALUOp         = ALUOP_ADD;
      halted        = 1'b0;
      illegal_op    = 1'b0;
      instr_retired = 1'b0;
    end
  end

  assign dbg_state = STW'(state_q);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for the multicycle sequencer against a per-instruction step-table model.
module tb_multicycle_sequencer;
  import seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       run = 1'b1;
  logic       PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemtoReg, Instr26, RegSelect1;
  logic [1:0] RegSelect2, ALUSrcA, ALUSrcB, PCSource, ALUOp;
  logic       halted, illegal_op, instr_retired;
  logic [3:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic sticky = 1'b0;

  typedef struct packed {
    logic       pcw, pcwc, irw, rw, mw, m2r, i26, rs1;
    logic [1:0] rs2, srca, srcb, pcs, aop;
    logic       halted, ill, ret;
    logic [3:0] st;
  } obs_t;

  obs_t obs;

  multicycle_sequencer #(.OPW(6), .STW(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .run(run),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Instr26(Instr26), .RegSelect1(RegSelect1),
    .RegSelect2(RegSelect2), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .halted(halted), .illegal_op(illegal_op), .instr_retired(instr_retired),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  always_comb begin
    obs        = '0;
    obs.pcw    = PCWrite;
    obs.pcwc   = PCWriteCond;
    obs.irw    = IRWrite;
    obs.rw     = RegWrite;
    obs.mw     = MemWrite;
    obs.m2r    = MemtoReg;
    obs.i26    = Instr26;
    obs.rs1    = RegSelect1;
    obs.rs2    = RegSelect2;
    obs.srca   = ALUSrcA;
    obs.srcb   = ALUSrcB;
    obs.pcs    = PCSource;
    obs.aop    = ALUOp;
    obs.halted = halted;
    obs.ill    = illegal_op;
    obs.ret    = instr_retired;
    obs.st     = dbg_state;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [5:0] op);
    return !(op[5:4] == 2'b00 || op[5:4] == 2'b01 || op == 6'h20 || op == 6'h21 ||
             op == 6'h22 || op == 6'h23 || op == 6'h30 || op == 6'h3f);
  endfunction

  localparam int HALT_HOLD = 20;

  function automatic int n_steps(input logic [5:0] op);
    if (op[5:4] == 2'b00 || op[5:4] == 2'b01) return 4;
    if (op == 6'h20) return 5;
    if (op == 6'h21) return 4;
    if (op == 6'h22 || op == 6'h23 || op == 6'h30) return 3;
    if (op == 6'h3f) return 2 + HALT_HOLD;
    return 2;
  endfunction

  // Expected outputs for step k (0 = fetch cycle) of one instruction.
  function automatic obs_t exp_step(input logic [5:0] op, input int k, input logic stk);
    obs_t e;
    bit is_r, is_i, lw, sw, br, jmp, hlt;
    is_r = (op[5:4] == 2'b00);
    is_i = (op[5:4] == 2'b01);
    lw   = (op == 6'h20);
    sw   = (op == 6'h21);
    br   = (op == 6'h22 || op == 6'h23);
    jmp  = (op == 6'h30);
    hlt  = (op == 6'h3f);
    e = '0;
    e.ill = stk;
    if (k == 0) begin
      e.st = S_FETCH; e.irw = 1; e.pcw = 1; e.srcb = 2'd1;
      return e;
    end
    if (is_r) begin e.rs1 = 1; e.rs2 = 2'd1; end
    else if (is_i || lw) e.rs1 = 1;
    else if (sw) begin e.rs1 = 1; e.rs2 = 2'd2; end
    if (k == 1) begin
      e.st = S_DECODE; e.srcb = 2'd2;
      if (is_illegal(op)) begin e.ill = 1; e.ret = 1; end
      return e;
    end
    if (hlt) begin
      e.st = S_HALT; e.halted = 1;
    end else if (is_r || is_i) begin
      if (k == 2) begin
        e.st = is_r ? S_EXEC_R : S_EXEC_I; e.srca = 2'd1;
        e.srcb = is_r ? 2'd0 : (op[3] ? 2'd3 : 2'd2);
        e.aop  = is_r ? 2'b10 : 2'b11;
      end else begin
        e.st = S_ALU_WB; e.rw = 1; e.ret = 1;
      end
    end else if (lw || sw) begin
      if (k == 2) begin
        e.st = S_MEM_ADDR; e.srca = 2'd1; e.srcb = 2'd2;
      end else if (sw) begin
        e.st = S_MEM_WR; e.mw = 1; e.ret = 1;
      end else if (k == 3) begin
        e.st = S_MEM_RD;
      end else begin
        e.st = S_MEM_WB; e.rw = 1; e.m2r = 1; e.ret = 1;
      end
    end else if (br) begin
      e.st = S_BRANCH; e.srca = 2'd1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'd1;
      e.i26 = op[0]; e.ret = 1;
    end else if (jmp) begin
      e.st = S_JUMP; e.pcw = 1; e.pcs = 2'd2; e.ret = 1;
    end
    return e;
  endfunction

  // Entered at a negedge while the FSM sits in FETCH; leaves at the negedge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input bit wiggle_run);
    int n;
    n = n_steps(op);
    opcode = op;
    run = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && wiggle_run) run = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("op%02h_step%0d", op, k), 64'(obs), 64'(exp_step(op, k, sticky)));
      @(negedge clock);
    end
    run = 1'b1;
    if (is_illegal(op)) sticky = 1'b1;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0: op = {2'b00, 4'($urandom)};
      1: op = {2'b01, 4'($urandom)};
      2: op = 6'h20;
      3: op = 6'h21;
      4: op = 6'h22;
      5: op = 6'h23;
      6: op = 6'h30;
      default: begin
        op = {1'b1, 5'($urandom)};
        while (!is_illegal(op)) op = {1'b1, 5'($urandom)};
      end
    endcase
    return op;
  endfunction

  initial begin
    reset = 1'b1;
    run   = 1'b1;
    opcode = 6'b000011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("reset_hold%0d", c), 64'(obs), 64'(0));
    end
    reset = 1'b0;

    // Directed pass through every instruction class.
    run_instr(6'b000011, 0);
    run_instr(6'b100000, 0);
    run_instr(6'b100011, 0);
    run_instr(6'b100010, 0);
    run_instr(6'b011000, 0);
    run_instr(6'b010000, 0);
    run_instr(6'b101010, 0);
    run_instr(6'b000111, 0);
    run_instr(6'b110000, 0);
    run_instr(6'b100001, 0);

    // run low in FETCH parks the FSM with no writes.
    run = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      begin
        obs_t e;
        e = '0; e.ill = sticky; e.st = S_FETCH;
        chk($sformatf("run_low%0d", c), 64'(obs), 64'(e));
      end
      @(negedge clock);
    end

    for (int t = 0; t < 200; t++) run_instr(rand_op(), 1);

    // Reset asserted mid MEM_ADDR.
    opcode = 6'b100000;
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pre_rst_step%0d", k), 64'(obs), 64'(exp_step(6'b100000, k, sticky)));
      if (k < 2) @(negedge clock);
    end
    #1 reset = 1'b1;
    #1;
    chk("reset_mid_mem_addr", 64'(obs), 64'(0));
    sticky = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    run_instr(6'b100001, 0);
    run_instr(rand_op(), 1);

    run_instr(6'b111111, 1);
    reset = 1'b1;
    #1;
    chk("reset_after_halt", 64'(obs), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    run_instr(6'b000001, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
